fetch_decode_ctrl: RTL and testbench

- Multi-cycle fetch/decode/control unit sitting directly upstream of the register-file/ALU datapath.
- Fetches 32-bit instructions from an instruction memory over a req/ack handshake and holds them in an instruction register (IR).
- Splits the IR into opcode, rs, rt, rd and immediate fields for the datapath.
- Sequences the register-file write enable and PC update for addi, R-type, beq and halt.

---
 rtl/fetch_decode_ctrl_if.sv | 31 +++
 rtl/fetch_decode_ctrl.sv | 130 +++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_ctrl_if.sv
// Instruction-memory handshake plus decoded-field bundle between the
// fetch/decode controller and the register-file/ALU datapath.
interface fetch_decode_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        alu_zero;
    logic [5:0]  op_code;
    logic [4:0]  rd_reg1;
    logic [4:0]  rd_reg2;
    logic [15:0] imme;
    logic        wr_enable;
    logic [4:0]  wr_reg;
    logic [31:0] pc;
    logic        halted;
    logic        illegal_op;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr, op_code, rd_reg1, rd_reg2, imme,
               wr_enable, wr_reg, pc, halted, illegal_op, fetch_err,
        input  imem_ack, imem_data, alu_zero
    );

    modport slave (
        input  imem_req, imem_addr, op_code, rd_reg1, rd_reg2, imme,
               wr_enable, wr_reg, pc, halted, illegal_op, fetch_err,
        output imem_ack, imem_data, alu_zero
    );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/control unit: fetches into an IR, splits fields and
// sequences register-file writes and PC updates for addi, R-type, beq and halt.
module fetch_decode_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_decode_ctrl_if.master  bus
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpHalt  = 6'b111111;

    // Last wait-counter value still allowed in FETCH; one more idle cycle times out.
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        ferr_q, ferr_d;
    logic        imem_req;
    logic        wr_enable;
    logic [5:0]  opcode;
    logic [31:0] branch_off;

    assign opcode     = ir_q[31:26];
    assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        ferr_d    = ferr_q;
        imem_req  = 1'b0;
        wr_enable = 1'b0;

        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    pc_d    = pc_q + 32'd4;
                    wait_d  = '0;
                    state_d = StDecode;
                end else if (wait_q == WaitLast) begin
                    ferr_d  = 1'b1;
                    wait_d  = '0;
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDecode: begin
                case (opcode)
                    OpRtype, OpAddi, OpBeq: state_d = StExec;
                    OpHalt:                 state_d = StHalt;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = StFetch;
                    end
                endcase
            end
            StExec: begin
                if (opcode == OpBeq) begin
                    // pc already points past the branch.
                    if (bus.alu_zero) pc_d = pc_q + branch_off;
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StWb: begin
                wr_enable = 1'b1;
                state_d   = StFetch;
            end
            StHalt:  state_d = StHalt;
            StErr:   state_d = StErr;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.imem_addr  = pc_q;
    assign bus.op_code    = opcode;
    assign bus.rd_reg1    = ir_q[25:21];
    assign bus.rd_reg2    = ir_q[20:16];
    assign bus.imme       = ir_q[15:0];
    assign bus.wr_enable  = wr_enable;
    assign bus.wr_reg     = (opcode == OpRtype) ? ir_q[15:11] : ir_q[20:16];
    assign bus.pc         = pc_q;
    assign bus.halted     = (state_q == StHalt);
    assign bus.illegal_op = illegal_q;
    assign bus.fetch_err  = ferr_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: a table of instructions run back to back,
// then hand-written halt, reset and fetch-timeout sequences.
module tb_fetch_decode_ctrl;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam int unsigned MaxWait = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_decode_ctrl_if bus ();

    fetch_decode_ctrl #(
        .RESET_PC (ResetPc),
        .MAX_WAIT (MaxWait)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic        wr;
        logic [4:0]  wr_reg;
        int          lat;
        logic [31:0] next_pc;
        logic        illegal;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        int wr_cnt;
        int wr_at;
        logic [4:0] wr_seen;

        //          instr         z     op     rs     rt     imm       wr    wrreg  lat next    ill
        vecs[0] = '{32'h20010001, 1'b0, 6'h08, 5'd0,  5'd1,  16'h0001, 1'b1, 5'd1,  4, 32'd4,  1'b0};
        vecs[1] = '{32'h00221820, 1'b0, 6'h00, 5'd1,  5'd2,  16'h1820, 1'b1, 5'd3,  4, 32'd8,  1'b0};
        vecs[2] = '{32'h1000FFFF, 1'b1, 6'h04, 5'd0,  5'd0,  16'hFFFF, 1'b0, 5'd0,  3, 32'd8,  1'b0};
        vecs[3] = '{32'h1000FFFF, 1'b0, 6'h04, 5'd0,  5'd0,  16'hFFFF, 1'b0, 5'd0,  3, 32'd12, 1'b0};
        vecs[4] = '{32'h54000000, 1'b0, 6'h15, 5'd0,  5'd0,  16'h0000, 1'b0, 5'd0,  2, 32'd16, 1'b1};
        vecs[5] = '{32'h20000005, 1'b1, 6'h08, 5'd0,  5'd0,  16'h0005, 1'b1, 5'd0,  4, 32'd20, 1'b1};
        vecs[6] = '{32'h014B6020, 1'b0, 6'h00, 5'd10, 5'd11, 16'h6020, 1'b1, 5'd12, 4, 32'd24, 1'b1};
        vecs[7] = '{32'h10220003, 1'b1, 6'h04, 5'd1,  5'd2,  16'h0003, 1'b0, 5'd0,  3, 32'd40, 1'b1};

        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'h0;
        bus.alu_zero  = 1'b0;

        // Ack presented during reset must be ignored.
        rst = 1'b1;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h20010001;
        tick();
        tick();
        bus.imem_ack = 1'b0;
        rst = 1'b0;
        chk("rst_req", bus.imem_req, 1'b1);
        chk("rst_addr", bus.imem_addr, ResetPc);
        chk("rst_pc", bus.pc, ResetPc);
        chk("rst_op", bus.op_code, 6'd0);
        chk("rst_imm", bus.imme, 16'd0);
        chk("rst_wr", bus.wr_enable, 1'b0);
        chk("rst_flags", {bus.halted, bus.illegal_op, bus.fetch_err}, 3'b000);

        foreach (vecs[i]) begin
            chk($sformatf("v%0d_ready", i), bus.imem_req, 1'b1);
            bus.alu_zero  = vecs[i].zero;
            bus.imem_ack  = 1'b1;
            bus.imem_data = vecs[i].instr;
            tick();
            bus.imem_ack  = 1'b0;
            bus.imem_data = 32'hDEAD_BEEF;
            chk($sformatf("v%0d_op", i), bus.op_code, vecs[i].op);
            chk($sformatf("v%0d_rs", i), bus.rd_reg1, vecs[i].rs);
            chk($sformatf("v%0d_rt", i), bus.rd_reg2, vecs[i].rt);
            chk($sformatf("v%0d_imm", i), bus.imme, vecs[i].imm);
            lat = 1;
            wr_cnt = 0;
            wr_at = 0;
            wr_seen = '0;
            while (bus.imem_req !== 1'b1 && lat < 10) begin
                if (bus.wr_enable === 1'b1) begin
                    wr_cnt++;
                    wr_at = lat;
                    wr_seen = bus.wr_reg;
                end
                tick();
                lat++;
            end
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_wrcnt", i), wr_cnt, {31'd0, vecs[i].wr});
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_wrat", i), wr_at, 3);
                chk($sformatf("v%0d_wrreg", i), wr_seen, vecs[i].wr_reg);
            end
            chk($sformatf("v%0d_next", i), bus.imem_addr, vecs[i].next_pc);
            chk($sformatf("v%0d_ill", i), bus.illegal_op, vecs[i].illegal);
        end

        // Halt: absorbing, no requests until reset.
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'hFC00_0000;
        tick();
        bus.imem_ack  = 1'b0;
        chk("halt_pc", bus.pc, 32'd44);
        tick();
        for (int k = 0; k < 20; k++) begin
            bus.imem_ack = 1'b1;
            chk($sformatf("halt_state_%0d", k), {bus.halted, bus.imem_req, bus.wr_enable}, 3'b100);
            tick();
        end
        bus.imem_ack = 1'b0;
        do_reset();
        chk("halt_rst_pc", bus.pc, ResetPc);
        chk("halt_rst_req", bus.imem_req, 1'b1);
        chk("halt_rst_flags", {bus.halted, bus.illegal_op}, 2'b00);

        // Partial wait then reset: counter must restart from zero.
        for (int k = 0; k < 10; k++) tick();
        do_reset();
        for (int k = 0; k < int'(MaxWait) - 1; k++) tick();
        chk("wait_cleared_req", bus.imem_req, 1'b1);
        chk("wait_cleared_err", bus.fetch_err, 1'b0);

        // Full timeout: the MaxWait-th idle cycle sends the unit to ERR.
        tick();
        chk("timeout_err", bus.fetch_err, 1'b1);
        chk("timeout_req", bus.imem_req, 1'b0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h20010001;
        for (int k = 0; k < 5; k++) tick();
        bus.imem_ack = 1'b0;
        chk("err_sticky", {bus.fetch_err, bus.imem_req, bus.op_code}, {1'b1, 1'b0, 6'd0});

        // Ack on the last allowed cycle is accepted.
        do_reset();
        chk("err_rst", bus.fetch_err, 1'b0);
        for (int k = 0; k < int'(MaxWait) - 1; k++) tick();
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h20010001;
        tick();
        bus.imem_ack = 1'b0;
        chk("edge_ack_err", bus.fetch_err, 1'b0);
        chk("edge_ack_op", bus.op_code, 6'h08);
        chk("edge_ack_pc", bus.pc, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
